// File: rtl/sram_resp_pkg.sv
// Shared constants, the MMIO request struct and the byte-merge helper for sram_resp.
package sram_resp_pkg;
  localparam logic [15:0] MMIO_BASE = 16'hBFAF;
  localparam logic [15:0] LED_OFS   = 16'hF000;
  localparam logic [15:0] SW_OFS    = 16'hF004;
  localparam logic [15:0] TIMER_OFS = 16'hE000;

  typedef struct packed {
    logic        en;
    logic [3:0]  wen;
    logic [15:2] ofs;
    logic [31:0] wdata;
  } mmio_req_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  wen);
    logic [31:0] res;
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = wen[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return res;
  endfunction
endpackage

// File: rtl/sram_resp_if.sv
// SRAM-like instruction and data ports between the CPU core and sram_resp.
interface sram_resp_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  inst_sram_rdata, data_sram_rdata
  );
  modport slave (
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata,
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output inst_sram_rdata, data_sram_rdata
  );
endinterface

// File: rtl/sram_resp_mmio.sv
// LED / SWITCH / TIMER registers and their read mux; read data is the pre-update value.
// The free-running timer is only built when SRAM_RESP_TIMER_EN is defined.
module sram_resp_mmio
  import sram_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  mmio_req_t   req,
  input  logic [15:0] sw,
  output logic [31:0] rdata,
  output logic [15:0] led
);
  logic        hit_led, hit_sw, hit_timer;
  logic [31:0] timer_rd;

  assign hit_led   = req.ofs == LED_OFS[15:2];
  assign hit_sw    = req.ofs == SW_OFS[15:2];
  assign hit_timer = req.ofs == TIMER_OFS[15:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) led <= '0;
    else if (req.en && hit_led) begin
      if (req.wen[0]) led[7:0]  <= req.wdata[7:0];
      if (req.wen[1]) led[15:8] <= req.wdata[15:8];
    end
  end

`ifdef SRAM_RESP_TIMER_EN
  logic [31:0] timer_q;
  logic [31:0] timer_inc;
  assign timer_inc = timer_q + 32'd1;

  // A same-cycle write overlays only its enabled bytes onto the incremented value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) timer_q <= '0;
    else if (req.en && hit_timer && |req.wen) timer_q <= byte_merge(timer_inc, req.wdata, req.wen);
    else timer_q <= timer_inc;
  end
  assign timer_rd = timer_q;
`else
  logic unused_wdata;
  assign unused_wdata = ^{req.wdata[31:16], hit_timer};
  assign timer_rd     = '0;
`endif

  always_comb begin
    rdata = '0;
    if (hit_led)        rdata = {16'h0, led};
    else if (hit_sw)    rdata = {16'h0, sw};
    else if (hit_timer) rdata = timer_rd;
  end
endmodule

// File: rtl/sram_resp.sv
// Dual-port SRAM responder: shared word array, 1-cycle registered reads, MMIO window at 0xBFAFxxxx.
// Optional TIMER register via SRAM_RESP_TIMER_EN (see sram_resp_mmio).
module sram_resp
  import sram_resp_pkg::*;
#(
  parameter int    DEPTH     = 65536,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  sram_resp_if.slave  bus,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  logic          d_mmio, i_mmio, d_ram_wr;
  logic [AW-1:0] d_idx, i_idx;
  logic [31:0]   d_old, i_old, i_word, mmio_rdata;
  mmio_req_t     mmio_req;

  assign d_mmio   = bus.data_sram_addr[31:16] == MMIO_BASE;
  assign i_mmio   = bus.inst_sram_addr[31:16] == MMIO_BASE;
  assign d_idx    = bus.data_sram_addr[AW+1:2];
  assign i_idx    = bus.inst_sram_addr[AW+1:2];
  assign d_ram_wr = bus.data_sram_en && !d_mmio && |bus.data_sram_wen;
  assign d_old    = mem[d_idx];
  assign i_old    = mem[i_idx];

  // Instruction fetch sees a same-cycle data write to its word (write-first).
  assign i_word = (d_ram_wr && d_idx == i_idx)
                ? byte_merge(i_old, bus.data_sram_wdata, bus.data_sram_wen) : i_old;

  always_ff @(posedge clk) begin
    if (d_ram_wr) mem[d_idx] <= byte_merge(d_old, bus.data_sram_wdata, bus.data_sram_wen);
  end

  assign mmio_req = '{en:    bus.data_sram_en && d_mmio,
                      wen:   bus.data_sram_wen,
                      ofs:   bus.data_sram_addr[15:2],
                      wdata: bus.data_sram_wdata};

  sram_resp_mmio u_mmio (
    .clk   (clk),
    .rst   (rst),
    .req   (mmio_req),
    .sw    (sw),
    .rdata (mmio_rdata),
    .led   (led)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.inst_sram_rdata <= '0;
      bus.data_sram_rdata <= '0;
    end else begin
      if (bus.inst_sram_en) bus.inst_sram_rdata <= i_mmio ? '0 : i_word;
      if (bus.data_sram_en) bus.data_sram_rdata <= d_mmio ? mmio_rdata : d_old;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.inst_sram_wen, bus.inst_sram_wdata, bus.inst_sram_addr,
                         bus.data_sram_addr};
endmodule

// File: tb/tb_sram_resp.sv
// Self-checking bench for sram_resp: directed cases plus random traffic against a word-array model.
module tb_sram_resp;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sw  = 16'h0;
  logic [15:0] led;
  int          checks = 0;
  int          failures = 0;

  sram_resp_if bus();

  sram_resp #(.DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sw  (sw),
    .led (led)
  );

  always #5 clk = ~clk;

  logic [31:0] mdl_mem [DEPTH];
  logic [31:0] exp_i = 0, exp_d = 0, mdl_timer = 0;
  logic [15:0] mdl_led = 0;

  function automatic logic [31:0] apply_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] wen);
    logic [31:0] m;
    m = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step(input logic den, input logic [3:0] dwen, input logic [31:0] daddr,
                      input logic [31:0] dwdata, input logic ien, input logic [31:0] iaddr);
    logic [31:0] tmp, next_timer;
    logic [15:0] ofs;
    int          w;
    bus.data_sram_en    = den;
    bus.data_sram_wen   = dwen;
    bus.data_sram_addr  = daddr;
    bus.data_sram_wdata = dwdata;
    bus.inst_sram_en    = ien;
    bus.inst_sram_wen   = 4'h0;
    bus.inst_sram_addr  = iaddr;
    bus.inst_sram_wdata = $urandom;
    next_timer = mdl_timer + 32'd1;
    ofs = daddr[15:0] & 16'hFFFC;
    if (den) begin
      if (daddr[31:16] == 16'hBFAF) begin
        case (ofs)
          16'hF000: exp_d = {16'h0, mdl_led};
          16'hF004: exp_d = {16'h0, sw};
`ifdef SRAM_RESP_TIMER_EN
          16'hE000: exp_d = mdl_timer;
`endif
          default:  exp_d = 32'h0;
        endcase
        if (ofs == 16'hF000) begin
          tmp = apply_bytes({16'h0, mdl_led}, dwdata, dwen & 4'b0011);
          mdl_led = tmp[15:0];
        end
        if (ofs == 16'hE000) next_timer = apply_bytes(next_timer, dwdata, dwen);
      end else begin
        w = int'((daddr >> 2) % DEPTH);
        exp_d = mdl_mem[w];
        mdl_mem[w] = apply_bytes(mdl_mem[w], dwdata, dwen);
      end
    end
`ifdef SRAM_RESP_TIMER_EN
    mdl_timer = next_timer;
`endif
    // Fetch sees the memory after this cycle's data write.
    if (ien) exp_i = (iaddr[31:16] == 16'hBFAF) ? 32'h0 : mdl_mem[int'((iaddr >> 2) % DEPTH)];
    @(posedge clk);
    #1;
    chk("data_rdata", bus.data_sram_rdata, exp_d);
    chk("inst_rdata", bus.inst_sram_rdata, exp_i);
    chk("led", {16'h0, led}, {16'h0, mdl_led});
  endtask

  initial begin
    logic [31:0] a, ia;
    int          k;
    bus.inst_sram_en = 0; bus.inst_sram_wen = 0; bus.inst_sram_addr = 0; bus.inst_sram_wdata = 0;
    bus.data_sram_en = 0; bus.data_sram_wen = 0; bus.data_sram_addr = 0; bus.data_sram_wdata = 0;
    #2 rst = 1'b0;
    #1;
    chk("rst_data_rdata", bus.data_sram_rdata, 32'h0);
    chk("rst_inst_rdata", bus.inst_sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) step(1, 4'hF, i * 4, $urandom, 0, 0);

    // Full write then read back
    step(1, 4'hF, 32'h10, 32'hDEADBEEF, 0, 0);
    step(1, 4'h0, 32'h10, 32'h0, 0, 0);
    chk("wr_rd", bus.data_sram_rdata, 32'hDEADBEEF);
    // Partial byte write
    step(1, 4'hF, 32'h20, 32'hAABBCCDD, 0, 0);
    step(1, 4'b0101, 32'h20, 32'h11223344, 0, 0);
    step(1, 4'h0, 32'h20, 32'h0, 0, 0);
    chk("byte_merge", bus.data_sram_rdata, 32'hAA22CC44);
    // Cross-port hazard on word 4
    step(1, 4'hF, 32'h10, 32'h12345678, 1, 32'h10);
    chk("hazard_inst", bus.inst_sram_rdata, 32'h12345678);
    chk("hazard_data_old", bus.data_sram_rdata, 32'hDEADBEEF);
    // Aliasing: upper address bits ignored
    step(1, 4'h0, 32'h0100_0010 + DEPTH * 4, 32'h0, 0, 0);
    chk("alias", bus.data_sram_rdata, 32'h12345678);
    // LED, SWITCH and instruction-side MMIO
    sw = 16'h00FF;
    step(1, 4'hF, 32'hBFAF_F000, 32'h0000_A5A5, 1, 32'hBFAF_F004);
    chk("led_write", {16'h0, led}, 32'h0000_A5A5);
    chk("inst_mmio_zero", bus.inst_sram_rdata, 32'h0);
    step(1, 4'h0, 32'hBFAF_F004, 32'h0, 0, 0);
    chk("switch_read", bus.data_sram_rdata, 32'h0000_00FF);
    // Timer write, idle, two reads
    step(1, 4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE, 0, 0);
    step(0, 4'h0, 32'h0, 32'h0, 0, 0);
    step(1, 4'h0, 32'hBFAF_E000, 32'h0, 0, 0);
`ifdef SRAM_RESP_TIMER_EN
    chk("timer_a", bus.data_sram_rdata, 32'hFFFF_FFFF);
`else
    chk("timer_a", bus.data_sram_rdata, 32'h0);
`endif
    step(1, 4'h0, 32'hBFAF_E000, 32'h0, 0, 0);
    chk("timer_b", bus.data_sram_rdata, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k < 2) begin
        case ($urandom_range(0, 4))
          0: a = 32'hBFAF_F000;
          1: a = 32'hBFAF_F004;
          2: a = 32'hBFAF_E000;
          3: a = 32'hBFAF_F008;
          default: a = 32'hBFAF_F001;
        endcase
      end else begin
        a = $urandom;
        if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
      end
      k = $urandom_range(0, 9);
      if (k < 4) ia = a ^ 32'h0100_0003;
      else if (k == 4) ia = 32'hBFAF_F000;
      else begin
        ia = $urandom;
        if (ia[31:16] == 16'hBFAF) ia[30] = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) sw = 16'($urandom);
      step($urandom_range(0, 4) != 0, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
           a, $urandom, $urandom_range(0, 3) != 0, ia);
    end

    // Asynchronous reset mid-stream
    step(1, 4'hF, 32'h40, 32'hDEADBEEF, 0, 0);
    step(1, 4'h3, 32'hBFAF_F000, 32'h0000_1234, 1, 32'h40);
    step(1, 4'h0, 32'h40, 32'h0, 0, 0);
    chk("pre_rst", bus.data_sram_rdata, 32'hDEADBEEF);
    bus.data_sram_en = 0;
    bus.inst_sram_en = 0;
    #2 rst = 1'b0;
    #1;
    exp_d = 0; exp_i = 0; mdl_led = 0; mdl_timer = 0;
    chk("async_rst_data", bus.data_sram_rdata, 32'h0);
    chk("async_rst_inst", bus.inst_sram_rdata, 32'h0);
    chk("async_rst_led", {16'h0, led}, 32'h0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    step(1, 4'h0, 32'h40, 32'h0, 1, 32'h40);
    chk("post_rst_reread", bus.data_sram_rdata, 32'hDEADBEEF);
    step(1, 4'h0, 32'hBFAF_E000, 32'h0, 0, 0);
`ifdef SRAM_RESP_TIMER_EN
    chk("timer_after_rst", bus.data_sram_rdata, 32'h1);
`else
    chk("timer_after_rst", bus.data_sram_rdata, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
